// File: rtl/jttrack_pkg.sv
// Shared types and constants for the Track'n Field object path.
package jttrack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAW  = 2'd2
    } obj_state_t;

    localparam int         OBJ_W        = 16;
    localparam int         PXL_PER_WORD = 8;
    localparam logic [3:0] TRANSPARENT  = 4'd0;

endpackage

// File: rtl/jttrack_objbuf.sv
// Ping-pong object line buffer: one bank takes draw writes while the other is read and cleared.
// Latency: pxl is registered 1 clk after the rd_cen that samples raddr.
// Backpressure: none; the write and read/clear ports always address opposite banks.
module jttrack_objbuf
    import jttrack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_bank,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [3:0] wdata,
    input  logic       rd_cen,
    input  logic       rd_en,
    input  logic [7:0] raddr,
    output logic [3:0] pxl
);

    logic [3:0] mem [0:511];
    logic       rd_bank;
    logic       clr;

    assign rd_bank = ~wr_bank;
    assign clr     = rd_cen & rd_en;

    // Contents are deliberately not reset; readout clears each location behind it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, waddr}] <= wdata;
        end
        if (clr) begin
            mem[{rd_bank, raddr}] <= TRANSPARENT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pxl <= TRANSPARENT;
        end else if (rd_cen) begin
            pxl <= rd_en ? mem[{rd_bank, raddr}] : TRANSPARENT;
        end
    end

endmodule

// File: rtl/jttrack_objdraw.sv
// Object line drawer: takes one sprite descriptor, fetches two 8-pixel words, writes opaque pixels to the line buffer.
// Latency: 18 cen2 cycles per sprite with immediate rom_ok; pxl is registered 1 clk after pxl_cen.
// Backpressure: busy blocks new descriptors; rom_cs held until rom_ok. Palette PROM enabled by JTTRACK_OBJPROM_EN.
module jttrack_objdraw
    import jttrack_pkg::*;
#(
    parameter logic [7:0] HOFFSET = 8'd6
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic        cen2,
    input  logic        LHBL,
    input  logic        hinit_x,
    input  logic [8:0]  hdump,
    input  logic        draw,
    output logic        busy,
    input  logic [8:0]  code,
    input  logic [7:0]  xpos,
    input  logic [3:0]  pal,
    input  logic        hflip,
    input  logic        vflip,
    input  logic [3:0]  ysub,
    input  logic [3:0]  prog_data,
    input  logic [7:0]  prog_addr,
    input  logic        prog_en,
    output logic [13:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        rom_cs,
    input  logic        rom_ok,
    output logic [3:0]  pxl
);

    obj_state_t  state;
    logic [8:0]  code_l;
    logic [3:0]  ysub_l;
    logic [3:0]  pal_l;
    logic        hflip_l;
    logic        vflip_l;
    logic        half;
    logic [2:0]  cnt;
    logic [7:0]  x;
    logic [31:0] data;
    logic        bank;
    logic [2:0]  nib_sel;
    logic [3:0]  nibble;
    logic [3:0]  colour;
    logic        buf_we;
    logic        unused_in;

    assign unused_in = hdump[8];
    assign rom_addr  = {code_l, ysub_l ^ {4{vflip_l}}, half ^ hflip_l};

    always_comb begin
        nib_sel = hflip_l ? ~cnt : cnt;
        nibble  = data[{nib_sel, 2'b00} +: 4];
    end

`ifdef JTTRACK_OBJPROM_EN
    logic [3:0] prom [0:255];

    // Written only during download while the core is held in reset.
    always_ff @(posedge clk) begin
        if (prog_en) begin
            prom[prog_addr] <= prog_data;
        end
    end

    assign colour = prom[{pal_l, nibble}];
`else
    logic unused_prog;

    assign unused_prog = ^{prog_data, prog_addr, prog_en, pal_l};
    assign colour      = nibble;
`endif

    // A coincident line swap suppresses the pending write along with the draw.
    assign buf_we = cen2 & ~hinit_x & (state == ST_DRAW) & (colour != TRANSPARENT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            rom_cs  <= 1'b0;
            bank    <= 1'b0;
            half    <= 1'b0;
            cnt     <= 3'd0;
            x       <= 8'd0;
            data    <= 32'd0;
            code_l  <= 9'd0;
            ysub_l  <= 4'd0;
            pal_l   <= 4'd0;
            hflip_l <= 1'b0;
            vflip_l <= 1'b0;
        end else if (cen2) begin
            if (hinit_x) begin
                bank   <= ~bank;
                state  <= ST_IDLE;
                busy   <= 1'b0;
                rom_cs <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (draw) begin
                            code_l  <= code;
                            ysub_l  <= ysub;
                            pal_l   <= pal;
                            hflip_l <= hflip;
                            vflip_l <= vflip;
                            half    <= 1'b0;
                            x       <= xpos + HOFFSET;
                            busy    <= 1'b1;
                            rom_cs  <= 1'b1;
                            state   <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (rom_ok) begin
                            data   <= rom_data;
                            rom_cs <= 1'b0;
                            cnt    <= 3'd0;
                            state  <= ST_DRAW;
                        end
                    end
                    ST_DRAW: begin
                        x   <= x + 8'd1;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'(PXL_PER_WORD - 1)) begin
                            if (!half) begin
                                half   <= 1'b1;
                                rom_cs <= 1'b1;
                                state  <= ST_FETCH;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        rom_cs <= 1'b0;
                    end
                endcase
            end
        end
    end

    jttrack_objbuf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_bank (bank),
        .we      (buf_we),
        .waddr   (x),
        .wdata   (colour),
        .rd_cen  (pxl_cen),
        .rd_en   (LHBL),
        .raddr   (hdump[7:0]),
        .pxl     (pxl)
    );

endmodule
